and_share_arbiter: RTL and testbench

- Shares one registered W-bit bitwise-AND unit among N_REQ requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Each transaction returns the registered result a & b to the requester that issued it.
- Sits between the requester blocks and the shared AND datapath; that datapath is instantiated inside this block.

---
 rtl/and_share_arbiter_if.sv | 27 ++
 rtl/and_share_arbiter.sv | 126 ++++++++++++
 tb/tb_and_share_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/and_share_arbiter_if.sv
// Handshake bundle between the requester blocks and the shared AND arbiter.
// The requester side drives requests and operands. The arbiter side returns grants and responses.
interface and_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic                 en;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*W-1:0]   op_a;
    logic [N_REQ*W-1:0]   op_b;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     rsp_valid;
    logic [W-1:0]         rsp_data;
    logic                 busy;
    logic [CNT_W-1:0]     txn_cnt;

    modport master (
        output en, req, op_a, op_b,
        input  gnt, rsp_valid, rsp_data, busy, txn_cnt
    );

    modport slave (
        input  en, req, op_a, op_b,
        output gnt, rsp_valid, rsp_data, busy, txn_cnt
    );
endinterface

// File: rtl/and_share_arbiter.sv
// Round-robin arbiter that shares one registered W-bit AND unit among N_REQ requesters.
// Only one transaction is in flight at a time, so each transaction takes two cycles: grant, then response.
module and_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    and_share_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // The search starts just past the last winner, so the last winner becomes lowest priority.
    function automatic logic [PTR_W-1:0] next_winner(input logic [N_REQ-1:0] req_v,
                                                     input logic [PTR_W-1:0] ptr_v);
        logic [PTR_W-1:0] w_v;
        logic             found_v;
        int               idx_v;
        w_v     = ptr_v;
        found_v = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v = (int'(ptr_v) + k) % N_REQ;
            if (!found_v && req_v[idx_v]) begin
                w_v     = PTR_W'(idx_v);
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        return w_v;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i_v);
        logic [N_REQ-1:0] oh_v;
        oh_v      = '0;
        oh_v[i_v] = 1'b1;
        return oh_v;
    endfunction

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   txn_cnt_q, txn_cnt_d;
    logic [PTR_W-1:0]   pick_s;

    assign pick_s = next_winner(bus.req, ptr_q);

    // Next-state and registered-output logic for the IDLE/BUSY transaction sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        txn_cnt_d   = txn_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.en && (|bus.req)) begin
                    win_d   = pick_s;
                    a_d     = bus.op_a[pick_s*W +: W];
                    b_d     = bus.op_b[pick_s*W +: W];
                    gnt_d   = onehot(pick_s);
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // Completion does not look at req or en, so an accepted transaction always finishes.
            ST_BUSY: begin
                rsp_data_d  = a_q & b_q;
                rsp_valid_d = onehot(win_q);
                ptr_d       = win_q;
                txn_cnt_d   = txn_cnt_q + CNT_W'(1);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears them asynchronously, which drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_W'(N_REQ - 1);
            win_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.txn_cnt   = txn_cnt_q;
endmodule

// File: tb/tb_and_share_arbiter.sv
// Self-checking bench for and_share_arbiter: directed scenarios plus random traffic.
// A transaction-level reference model predicts every output after each clock edge.
module tb_and_share_arbiter;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    and_share_arbiter_if #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) bus ();

    and_share_arbiter #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the transaction that is pending and the requester served last.
    bit             m_pending;
    int             m_w;
    int             m_last;
    logic [W-1:0]   m_a, m_b;
    logic [N-1:0]   exp_gnt, exp_rsp_valid;
    logic [W-1:0]   exp_rsp_data;
    logic [CNT_W-1:0] exp_cnt;
    logic           exp_busy;
    bit             exp_rsp_event;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        check("gnt",       32'(bus.gnt),       32'(exp_gnt));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
        check("rsp_data",  32'(bus.rsp_data),  32'(exp_rsp_data));
        check("busy",      32'(bus.busy),      32'(exp_busy));
        check("txn_cnt",   32'(bus.txn_cnt),   32'(exp_cnt));
    endtask

    task automatic model_reset();
        m_pending     = 1'b0;
        m_w           = 0;
        m_last        = N - 1;
        exp_gnt       = '0;
        exp_rsp_valid = '0;
        exp_rsp_data  = '0;
        exp_cnt       = '0;
        exp_busy      = 1'b0;
        exp_rsp_event = 1'b0;
    endtask

    task automatic model_edge();
        exp_gnt       = '0;
        exp_rsp_valid = '0;
        exp_rsp_event = 1'b0;
        if (m_pending) begin
            exp_rsp_valid = '0;
            exp_rsp_valid[m_w] = 1'b1;
            exp_rsp_data  = m_a & m_b;
            exp_cnt       = exp_cnt + 1'b1;
            m_last        = m_w;
            m_pending     = 1'b0;
            exp_rsp_event = 1'b1;
        end else if (bus.en && bus.req != '0) begin
            bit found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                int idx = (m_last + i) % N;
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    m_w   = idx;
                end
            end
            exp_gnt[m_w] = 1'b1;
            m_a          = bus.op_a[m_w*W +: W];
            m_b          = bus.op_b[m_w*W +: W];
            m_pending    = 1'b1;
        end
        exp_busy = m_pending;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Assert reset mid-cycle, check the outputs clear at once, and release it on the falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] gnt_seen [$];
    int           resp;

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) step();

        // Single request from requester 1
        bus.en = 1'b1;
        bus.req = 4'b0010;
        bus.op_a[1*W +: W] = 8'hF0;
        bus.op_b[1*W +: W] = 8'h3C;
        step();
        check("single_gnt", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        bus.op_a = '0;
        step();
        check("single_data", 32'(bus.rsp_data), 32'h30);
        check("single_rsp", 32'(bus.rsp_valid), 32'h2);
        check("single_cnt", 32'(bus.txn_cnt), 32'h1);
        step();

        // All requesters held with distinct operands: rotation starts at 0
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.op_a[i*W +: W] = 8'(8'h5A + 8'(i * 37));
            bus.op_b[i*W +: W] = 8'(8'hC3 ^ 8'(i * 17));
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.gnt != '0) gnt_seen.push_back(bus.gnt);
        end
        check("rr_count", 32'(gnt_seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < gnt_seen.size(); i++)
            check("rr_order", 32'(gnt_seen[i]), 32'(1 << (i % N)));

        // Drop en after the grant: the response still completes, with no grants while en is low
        bus.req = 4'b1010;
        step();
        check("en_first_gnt", 32'(bus.gnt), 32'h2);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.en = 1'b1;
        step();
        check("en_resume_gnt", 32'(bus.gnt), 32'h8);
        step();

        // Reset during BUSY discards the transaction
        bus.req = 4'b0100;
        step();
        step();
        step();
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        do_reset();
        bus.req = 4'b1111;
        step();
        check("post_rst_gnt", 32'(bus.gnt), 32'h1);
        step();

        // Random traffic
        bus.req = '0;
        for (int i = 0; i < 200; i++) begin
            bus.en   = ($urandom_range(0, 3) != 0);
            bus.req  = N'($urandom);
            bus.op_a = (N*W)'($urandom);
            bus.op_b = (N*W)'($urandom);
            step();
        end

        // Counter wrap with the 4-bit counter
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        resp = 0;
        for (int i = 0; i < 80 && resp < 17; i++) begin
            step();
            if (exp_rsp_event) begin
                resp++;
                if (resp == 16) check("wrap16", 32'(bus.txn_cnt), 32'h0);
                if (resp == 17) check("wrap17", 32'(bus.txn_cnt), 32'h1);
            end
        end
        check("wrap_responses", 32'(resp), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
